// File: rtl/cla.sv
// 4-bit carry-look-ahead adder slice: all carries are resolved from the generate and
// propagate terms in two logic levels instead of rippling bit to bit.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one 4-bit CLA slice per cycle, LSB slice first,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         cla_s;
  logic               cla_cout;
  logic [WIDTH+3:0]   sum_cat;
  logic [WIDTH-1:0]   sum_sh_next;

  cla u_cla (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .s    (cla_s),
    .cout (cla_cout)
  );

  // New slice enters at the top; after NSLICE shifts slice k sits in bits 4k+3:4k.
  assign sum_cat     = {cla_s, sum_sh_q};
  assign sum_sh_next = sum_cat[WIDTH+3:4];

  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        sum_sh_d = sum_sh_next;
        carry_d  = cla_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d   = sum_sh_next;
          cout_d  = cla_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (sum_sh_next[WIDTH-1] != a_msb_q);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at WIDTH 16, 4 and 32.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        w4_in_valid, w4_in_ready, w4_cin, w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
  logic [3:0]  w4_a, w4_b, w4_sum;

  logic        w32_in_valid, w32_in_ready, w32_cin, w32_out_valid, w32_out_ready;
  logic        w32_cout, w32_ovf;
  logic [31:0] w32_a, w32_b, w32_sum;

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready), .a(w4_a),
    .b(w4_b), .cin(w4_cin), .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
  );

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready), .a(w32_a),
    .b(w32_b), .cin(w32_cin), .out_valid(w32_out_valid), .out_ready(w32_out_ready),
    .sum(w32_sum), .cout(w32_cout), .ovf(w32_ovf)
  );

  // Stimulus helpers for the 16-bit DUT; all called #1 after a rising edge.
  task automatic accept16(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    a = aa; b = bb; cin = cc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    checks++;
    if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs sum=%h cout=%b ovf=%b required 0 0 0", sum, cout, ovf);
    end
    checks++;
    if (w4_in_ready !== 1'b0 || w32_in_ready !== 1'b0 || w4_out_valid !== 1'b0
        || w32_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags_w4_w32 got %b%b%b%b required 0000", w4_in_ready, w32_in_ready,
               w4_out_valid, w32_out_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    int lat;
    accept16(16'hFFFF, 16'h0001, 1'b0);
    wait_valid16(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL ripple_latency got %0d required 4", lat);
    end
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ripple_result sum=%h cout=%b ovf=%b required 0000 1 0", sum, cout, ovf);
    end
    drain16();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ripple_drain in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    int lat;
    accept16(16'h7FFF, 16'h0001, 1'b0);
    wait_valid16(lat);
    checks++;
    if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL ovf_pos sum=%h cout=%b ovf=%b lat=%0d required 8000 0 1 4",
               sum, cout, ovf, lat);
    end
    drain16();
    accept16(16'h8000, 16'h8000, 1'b0);
    wait_valid16(lat);
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1 || lat != 4) begin
      errors++;
      $display("FAIL ovf_neg sum=%h cout=%b ovf=%b lat=%0d required 0000 1 1 4",
               sum, cout, ovf, lat);
    end
    drain16();
  endtask

  task automatic test_backpressure();
    int lat;
    accept16(16'h1234, 16'h4321, 1'b1);
    wait_valid16(lat);
    checks++;
    if (sum !== 16'h5556 || cout !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL bp_result sum=%h cout=%b lat=%0d required 5556 0 4", sum, cout, lat);
    end
    // Operands offered during DONE must be ignored.
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b sum=%h cout=%b in_ready=%b required 1 5556 0 0",
                 i, out_valid, sum, cout, in_ready);
      end
    end
    in_valid = 1'b0;
    drain16();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h5556) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b sum=%h required 1 0 5556",
               in_ready, out_valid, sum);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    accept16(16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== 16'h0 || cout !== 1'b0
        || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs ov=%b ir=%b sum=%h cout=%b ovf=%b required 0 0 0000 0 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_abort out_valid_seen=%b in_ready=%b required 0 1", seen, in_ready);
    end
    accept16(16'h0F0F, 16'h00F1, 1'b0);
    wait_valid16(lat);
    checks++;
    if (sum !== 16'h1000 || cout !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL midreset_next sum=%h cout=%b lat=%0d required 1000 0 4", sum, cout, lat);
    end
    drain16();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] es [4];
    logic        vc [4];
    logic        ec [4];
    int nin, nout, last;
    logic acc;
    va = '{16'h0001, 16'hFFFF, 16'h8421, 16'h0F0F};
    vb = '{16'h0002, 16'hFFFF, 16'h7BDF, 16'hF0F0};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1};
    es = '{16'h0003, 16'hFFFF, 16'h0000, 16'h0000};
    ec = '{1'b0, 1'b1, 1'b1, 1'b1};
    nin = 0; nout = 0; last = 0;
    a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && nout < 4; cyc++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        checks++;
        if (sum !== es[nout] || cout !== ec[nout]) begin
          errors++;
          $display("FAIL b2b_result idx=%0d sum=%h cout=%b required %h %b",
                   nout, sum, cout, es[nout], ec[nout]);
        end
        if (nout > 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++;
            $display("FAIL b2b_interval idx=%0d got %0d required 6", nout, cyc - last);
          end
        end
        last = cyc;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) begin
        nin++;
        if (nin < 4) begin
          a = va[nin]; b = vb[nin]; cin = vc[nin];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (nin != 4 || nout != 4) begin
      errors++;
      $display("FAIL b2b_count accepted=%0d results=%0d required 4 4", nin, nout);
    end
  endtask

  task automatic test_random16();
    logic [15:0] aa, bb;
    logic        cc, eovf;
    logic [16:0] exp;
    int lat;
    for (int i = 0; i < 300; i++) begin
      aa = 16'($urandom); bb = 16'($urandom); cc = 1'($urandom_range(0, 1));
      exp = {1'b0, aa} + {1'b0, bb} + {16'h0, cc};
      eovf = (aa[15] == bb[15]) && (exp[15] != aa[15]);
      accept16(aa, bb, cc);
      wait_valid16(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1 || {cout, sum} !== exp || ovf !== eovf || lat != 4) begin
        errors++;
        $display("FAIL rand16 a=%h b=%h cin=%b got %b_%h ovf=%b lat=%0d required %h ovf=%b lat=4",
                 aa, bb, cc, cout, sum, ovf, lat, exp, eovf);
      end
      drain16();
    end
  endtask

  task automatic test_width4();
    logic [3:0] aa, bb;
    logic       cc, eovf;
    logic [4:0] exp;
    int lat;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        aa = 4'hF; bb = 4'h1; cc = 1'b0;
      end else begin
        aa = 4'($urandom); bb = 4'($urandom); cc = 1'($urandom_range(0, 1));
      end
      exp = {1'b0, aa} + {1'b0, bb} + {4'h0, cc};
      eovf = (aa[3] == bb[3]) && (exp[3] != aa[3]);
      w4_a = aa; w4_b = bb; w4_cin = cc; w4_in_valid = 1'b1;
      @(posedge clk); #1;
      w4_in_valid = 1'b0;
      lat = 0;
      while (!w4_out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      if (i == 0) begin
        checks++;
        if (w4_sum !== 4'h0 || w4_cout !== 1'b1 || lat != 1) begin
          errors++;
          $display("FAIL w4_directed sum=%h cout=%b lat=%0d required 0 1 1", w4_sum, w4_cout, lat);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (w4_out_valid !== 1'b1 || {w4_cout, w4_sum} !== exp || w4_ovf !== eovf || lat != 1) begin
        errors++;
        $display("FAIL w4_rand a=%h b=%h cin=%b got %b_%h ovf=%b lat=%0d required %h ovf=%b lat=1",
                 aa, bb, cc, w4_cout, w4_sum, w4_ovf, lat, exp, eovf);
      end
      w4_out_ready = 1'b1;
      @(posedge clk); #1;
      w4_out_ready = 1'b0;
    end
  endtask

  task automatic test_width32();
    logic [31:0] aa, bb;
    logic        cc, eovf;
    logic [32:0] exp;
    int lat;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        aa = 32'hFFFF_FFFF; bb = 32'h0; cc = 1'b1;
      end else begin
        aa = $urandom; bb = $urandom; cc = 1'($urandom_range(0, 1));
      end
      exp = {1'b0, aa} + {1'b0, bb} + {32'h0, cc};
      eovf = (aa[31] == bb[31]) && (exp[31] != aa[31]);
      w32_a = aa; w32_b = bb; w32_cin = cc; w32_in_valid = 1'b1;
      @(posedge clk); #1;
      w32_in_valid = 1'b0;
      lat = 0;
      while (!w32_out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      if (i == 0) begin
        checks++;
        if (w32_sum !== 32'h0 || w32_cout !== 1'b1 || w32_ovf !== 1'b0 || lat != 8) begin
          errors++;
          $display("FAIL w32_directed sum=%h cout=%b ovf=%b lat=%0d required 0 1 0 8",
                   w32_sum, w32_cout, w32_ovf, lat);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (w32_out_valid !== 1'b1 || {w32_cout, w32_sum} !== exp || w32_ovf !== eovf
          || lat != 8) begin
        errors++;
        $display("FAIL w32_rand a=%h b=%h cin=%b got %b_%h ovf=%b lat=%0d required %h ovf=%b lat=8",
                 aa, bb, cc, w32_cout, w32_sum, w32_ovf, lat, exp, eovf);
      end
      w32_out_ready = 1'b1;
      @(posedge clk); #1;
      w32_out_ready = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_out_ready = 1'b0;
    w32_in_valid = 1'b0; w32_a = '0; w32_b = '0; w32_cin = 1'b0; w32_out_ready = 1'b0;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random16();
    test_width4();
    test_width32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
